// File: rtl/spi_flash_line_reader_if.sv
// Bus-side port bundle for spi_flash_line_reader.
//   word_address  CPU -> reader  word address, sampled with rstrb
//   rstrb         CPU -> reader  one-cycle read strobe
//   flush         CPU -> reader  invalidate the line buffer
//   rdata         reader -> CPU  32-bit read data
//   rbusy         reader -> CPU  high while a miss is being serviced
interface spi_flash_line_reader_if #(
  parameter int WORD_ADDR_WIDTH = 20
);
  logic [WORD_ADDR_WIDTH-1:0] word_address;
  logic                       rstrb;
  logic                       flush;
  logic [31:0]                rdata;
  logic                       rbusy;

  modport master (output word_address, rstrb, flush, input rdata, rbusy);
  modport slave  (input word_address, rstrb, flush, output rdata, rbusy);
endinterface

// File: rtl/spi_flash_line_reader.sv
// Memory-mapped read-only SPI flash port (mode 0) with a one-line read buffer.
// A miss fetches a whole line in one burst; hits return the next cycle with no stall.
// Ports:
//   clk, resetn         system clock, asynchronous active-low reset
//   bus (slave)         word_address/rstrb/flush in, rdata/rbusy out
//   CLK, CS_N, MOSI     SPI clock, chip select (active low), data to flash
//   MISO                SPI data from flash
//
// state   | meaning
// --------+-------------------------------------------------
// S_IDLE  | waiting for rstrb; hits served here
// S_CMD   | shifting out the 8-bit read command
// S_ADDR  | shifting out the 24-bit line-base byte address
// S_DUMMY | 8 dummy SCK cycles (fast-read only)
// S_DATA  | receiving 32*LINE_WORDS bits into the line buffer
// S_DONE  | deliver word, release CS_N, mark line valid
module spi_flash_line_reader #(
  parameter int WORD_ADDR_WIDTH = 20,
  parameter int LINE_WORDS      = 4,
  parameter int FAST_READ       = 0,
  parameter int CLK_DIV         = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  spi_flash_line_reader_if.slave  bus,
  output logic                    CLK,
  output logic                    CS_N,
  output logic                    MOSI,
  input  logic                    MISO
);
  localparam int W         = WORD_ADDR_WIDTH;
  localparam int IDX_W     = $clog2(LINE_WORDS);
  localparam int IW        = (IDX_W == 0) ? 1 : IDX_W;
  localparam int NSLOT     = 1 << IW;
  localparam int DATA_BITS = 32 * LINE_WORDS;
  localparam int PH_W      = $clog2(2 * CLK_DIV + 1);
  localparam logic [PH_W-1:0] PH_TOP    = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0] PH_RISE   = PH_W'(CLK_DIV);
  localparam logic [9:0]      DATA_LAST = 10'(DATA_BITS - 1);
  localparam logic [7:0]      CMD_BYTE  = (FAST_READ != 0) ? 8'h0B : 8'h03;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [PH_W-1:0] ph_q, ph_d;     // phase within a bit, counts down
  logic [9:0]      bit_q, bit_d;   // bits left in the current state, minus one

  logic            valid_q, flush_pend_q;
  logic [W-1:0]    tag_q;
  logic [IW-1:0]   idx_q;
  logic [31:0]     tx_q;
  logic [31:0]     line_q [NSLOT];

  logic [W-1:0]    req_tag;
  logic [IW-1:0]   req_idx;
  logic [W+25:0]   base_ext;
  logic [23:0]     req_base;
  logic            hit, start, bit_end, last_bit, spi_d;
  logic [9:0]      rx_m;
  logic [IW-1:0]   rx_word;
  logic [4:0]      rx_pos;

  assign req_tag  = bus.word_address >> IDX_W;
  assign req_idx  = IW'(bus.word_address & W'(LINE_WORDS - 1));
  // Zero-extend (or truncate) the line-base byte address to 24 bits.
  assign base_ext = {24'b0, bus.word_address & ~W'(LINE_WORDS - 1), 2'b00};
  assign req_base = base_ext[23:0];

  // A flush in the same cycle as the strobe forces a miss.
  assign hit      = valid_q && !bus.flush && (tag_q == req_tag);
  assign start    = (state_q == S_IDLE) && bus.rstrb && !hit;
  assign bit_end  = (ph_q == '0);
  assign last_bit = bit_end && (bit_q == '0);
  assign spi_d    = state_d inside {S_CMD, S_ADDR, S_DUMMY, S_DATA};

  // Received bit m of the burst: byte m/8 lands in word m/32, lane (m/8)%4, MSB first.
  assign rx_m    = DATA_LAST - bit_q;
  assign rx_word = IW'(rx_m >> 5);
  assign rx_pos  = {rx_m[4:3], ~rx_m[2:0]};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CMD;
          ph_d    = PH_TOP;
          bit_d   = 10'd7;
        end
      end
      S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
        ph_d = bit_end ? PH_TOP : ph_q - 1'b1;
        if (bit_end && bit_q != '0) bit_d = bit_q - 1'b1;
        if (last_bit) begin
          case (state_q)
            S_CMD: begin
              state_d = S_ADDR;
              bit_d   = 10'd23;
            end
            S_ADDR: begin
              state_d = (FAST_READ != 0) ? S_DUMMY : S_DATA;
              bit_d   = (FAST_READ != 0) ? 10'd7 : DATA_LAST;
            end
            S_DUMMY: begin
              state_d = S_DATA;
              bit_d   = DATA_LAST;
            end
            default: state_d = S_DONE;
          endcase
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.rdata    <= '0;
      bus.rbusy    <= 1'b0;
      CLK          <= 1'b0;
      CS_N         <= 1'b1;
      MOSI         <= 1'b0;
      valid_q      <= 1'b0;
      flush_pend_q <= 1'b0;
      tag_q        <= '0;
      idx_q        <= '0;
      tx_q         <= '0;
      for (int i = 0; i < NSLOT; i++) line_q[i] <= '0;
    end else begin
      // SCK is low for the first half of each bit, high for the second.
      CLK  <= spi_d && (ph_d < PH_RISE);
      CS_N <= !spi_d;
      case (state_q)
        S_IDLE: begin
          if (bus.flush) valid_q <= 1'b0;
          if (bus.rstrb) begin
            if (hit) begin
              bus.rdata <= line_q[req_idx];
            end else begin
              bus.rbusy    <= 1'b1;
              valid_q      <= 1'b0;
              flush_pend_q <= 1'b0;
              tag_q        <= req_tag;
              idx_q        <= req_idx;
              MOSI         <= CMD_BYTE[7];
              tx_q         <= {CMD_BYTE[6:0], req_base, 1'b0};
            end
          end
        end
        S_CMD, S_ADDR, S_DUMMY, S_DATA: begin
          if (bus.flush) flush_pend_q <= 1'b1;
          if (bit_end) begin
            MOSI <= (state_d == S_CMD || state_d == S_ADDR) ? tx_q[31] : 1'b0;
            tx_q <= tx_q << 1;
          end
          if (state_q == S_DATA && ph_q == PH_RISE) line_q[rx_word][rx_pos] <= MISO;
        end
        S_DONE: begin
          bus.rdata <= line_q[idx_q];
          bus.rbusy <= 1'b0;
          valid_q   <= !(flush_pend_q || bus.flush);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_flash_line_reader.sv
module tb_spi_flash_line_reader;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  spi_flash_line_reader_if #(.WORD_ADDR_WIDTH(20)) bus0 ();
  spi_flash_line_reader_if #(.WORD_ADDR_WIDTH(20)) bus1 ();

  logic sck0, csn0, mosi0;
  logic sck1, csn1, mosi1;
  logic miso0 = 1'b0;
  logic miso1 = 1'b0;

  spi_flash_line_reader #(.WORD_ADDR_WIDTH(20)) dut0 (
    .clk(clk), .resetn(resetn), .bus(bus0),
    .CLK(sck0), .CS_N(csn0), .MOSI(mosi0), .MISO(miso0));

  spi_flash_line_reader #(.WORD_ADDR_WIDTH(20), .LINE_WORDS(1), .FAST_READ(1), .CLK_DIV(2)) dut1 (
    .clk(clk), .resetn(resetn), .bus(bus1),
    .CLK(sck1), .CS_N(csn1), .MOSI(mosi1), .MISO(miso1));

  int errors = 0;
  int checks = 0;

  // Flash contents: identity for the low 256 bytes, mixed above that.
  function automatic logic [7:0] fmem(input logic [23:0] a);
    return a[7:0] ^ a[15:8];
  endfunction

  function automatic logic [31:0] fword(input logic [19:0] w);
    logic [23:0] a;
    a = {2'b00, w, 2'b00};
    return {fmem(24'(a + 3)), fmem(24'(a + 2)), fmem(24'(a + 1)), fmem(a)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Flash slave models (mode 0): capture cmd+addr on SCK rise, shift data out on SCK fall.
  int rise0 = 0, rise1 = 0;
  logic [31:0] hdr0 = '0, hdr1 = '0;

  always @(negedge csn0) begin rise0 = 0; hdr0 = '0; end
  always @(posedge sck0) begin
    if (!csn0) begin
      if (rise0 < 32) hdr0 = {hdr0[30:0], mosi0};
      rise0++;
    end
  end
  always @(negedge sck0) begin
    int j;
    logic [7:0] b;
    if (!csn0 && rise0 >= 32) begin
      j = rise0 - 32;
      b = fmem(24'(hdr0[23:0] + 24'(j / 8)));
      miso0 = b[7 - (j % 8)];
    end
  end

  always @(negedge csn1) begin rise1 = 0; hdr1 = '0; end
  always @(posedge sck1) begin
    if (!csn1) begin
      if (rise1 < 32) hdr1 = {hdr1[30:0], mosi1};
      rise1++;
    end
  end
  always @(negedge sck1) begin
    int j;
    logic [7:0] b;
    if (!csn1 && rise1 >= 40) begin
      j = rise1 - 40;
      b = fmem(24'(hdr1[23:0] + 24'(j / 8)));
      miso1 = b[7 - (j % 8)];
    end
  end

  int csl0 = 0, csl1 = 0, busyc0 = 0;
  always @(negedge clk) begin
    if (!csn0) csl0++;
    if (!csn1) csl1++;
    if (bus0.rbusy) busyc0++;
  end

  // Reference model of the line buffer for the default instance.
  bit          valid_m = 1'b0;
  logic [17:0] tag_m = '0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd0(input logic [19:0] w, input bit fl_same, input int flush_at, output bit was_miss);
    bit   exp_hit;
    int   cnt, cs_start;
    logic [31:0] expw;
    expw     = fword(w);
    exp_hit  = valid_m && !fl_same && (w[19:2] == tag_m);
    cs_start = csl0;
    bus0.word_address = w;
    bus0.rstrb = 1'b1;
    bus0.flush = fl_same;
    step();
    bus0.rstrb = 1'b0;
    bus0.flush = 1'b0;
    was_miss = bus0.rbusy;
    chk("strobe_busy", bus0.rbusy, !exp_hit);
    if (exp_hit) begin
      chk("hit_data", bus0.rdata, expw);
    end
    cnt = 0;
    while (bus0.rbusy && cnt < 2000) begin
      if (cnt == flush_at) bus0.flush = 1'b1;
      step();
      bus0.flush = 1'b0;
      cnt++;
    end
    if (!exp_hit) begin
      chk("miss_latency", cnt, 321);
      chk("miss_data", bus0.rdata, expw);
      chk("miss_cs_low", csl0 - cs_start, 320);
      chk("miss_hdr", hdr0, {8'h03, 2'b00, w[19:2], 4'b0000});
      valid_m = (flush_at < 0);
      tag_m   = w[19:2];
    end
  endtask

  initial begin
    bit miss;
    int cnt, cs_start, b0;
    logic [19:0] w, base;
    bus0.word_address = '0; bus0.rstrb = 1'b0; bus0.flush = 1'b0;
    bus1.word_address = '0; bus1.rstrb = 1'b0; bus1.flush = 1'b0;
    resetn = 1'b0;
    repeat (3) step();
    chk("rst_rdata", bus0.rdata, 32'h0);
    chk("rst_rbusy", bus0.rbusy, 1'b0);
    chk("rst_clk", sck0, 1'b0);
    chk("rst_csn", csn0, 1'b1);
    chk("rst_mosi", mosi0, 1'b0);
    resetn = 1'b1;
    step();

    // Line fetch at word 0x10, then hits in the same line.
    rd0(20'h00010, 1'b0, -1, miss);
    chk("t1_data", bus0.rdata, 32'h43424140);
    b0 = busyc0;
    rd0(20'h00011, 1'b0, -1, miss);
    chk("t2_data_11", bus0.rdata, 32'h47464544);
    rd0(20'h00013, 1'b0, -1, miss);
    chk("t2_data_13", bus0.rdata, 32'h4F4E4D4C);
    chk("t2_no_busy", busyc0 - b0, 0);

    // Other line, then back: both miss.
    rd0(20'h00014, 1'b0, -1, miss);
    chk("t3_hdr", hdr0, 32'h03000050);
    rd0(20'h00010, 1'b0, -1, miss);
    chk("t3_remiss", miss, 1'b1);

    // Fast read, divider 2, one-word lines.
    cs_start = csl1;
    bus1.word_address = 20'h00003;
    bus1.rstrb = 1'b1;
    step();
    bus1.rstrb = 1'b0;
    cnt = 0;
    while (bus1.rbusy && cnt < 2000) begin step(); cnt++; end
    chk("t4_latency", cnt, 289);
    chk("t4_data", bus1.rdata, 32'h0F0E0D0C);
    chk("t4_hdr", hdr1, 32'h0B00000C);
    chk("t4_sck_rises", rise1, 72);
    chk("t4_cs_low", csl1 - cs_start, 288);

    // Flush mid-burst: data still delivered, line left invalid.
    rd0(20'h00020, 1'b0, 50, miss);
    chk("t5_data", bus0.rdata, 32'h83828180);
    rd0(20'h00020, 1'b0, -1, miss);
    chk("t5_remiss", miss, 1'b1);

    // Async reset in the middle of the data phase.
    bus0.word_address = 20'h00030;
    bus0.rstrb = 1'b1;
    step();
    bus0.rstrb = 1'b0;
    repeat (150) step();
    resetn = 1'b0;
    #1;
    chk("t6_csn", csn0, 1'b1);
    chk("t6_clk", sck0, 1'b0);
    chk("t6_rbusy", bus0.rbusy, 1'b0);
    valid_m = 1'b0;
    step();
    resetn = 1'b1;
    step();
    rd0(20'h00030, 1'b0, -1, miss);
    chk("t6_remiss", miss, 1'b1);

    // Randomized reads over a few line pools with occasional flushes.
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 2))
        0:       base = 20'h00000;
        1:       base = 20'h0ABC0;
        default: base = 20'hFFFF0;
      endcase
      w = 20'(base + 20'($urandom_range(0, 15)));
      if ($urandom_range(0, 6) == 0) begin
        bus0.flush = 1'b1;
        step();
        bus0.flush = 1'b0;
        valid_m = 1'b0;
      end
      rd0(w, ($urandom_range(0, 5) == 0), (($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 300)) : -1), miss);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
